// File: rtl/path_count_processor.sv
// Counts distinct src->dst paths over a streamed edge list using a two-bank wavefront sweep.
// Define PATH_COUNT_SATURATE_EN to clamp wave/total additions instead of wrapping.
module path_count_processor #(
    parameter int unsigned DEVICE_WIDTH = 15,
    parameter int unsigned MAX_EDGES    = 1024,
    parameter int unsigned RESULT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    test_logic_reset,
    input  logic                    end_of_file,
    input  logic                    connection_valid,
    input  logic                    connection_last,
    input  logic [DEVICE_WIDTH-1:0] device,
    input  logic [DEVICE_WIDTH-1:0] next_device,
    input  logic [DEVICE_WIDTH-1:0] src_device,
    input  logic [DEVICE_WIDTH-1:0] dst_device,
    output logic                    busy,
    output logic                    result_valid,
    output logic [RESULT_WIDTH-1:0] result_data,
    output logic                    overflow,
    output logic                    error
);

    localparam int unsigned EDGE_WIDTH = 2 * DEVICE_WIDTH + 1;
    localparam int unsigned EIDX_WIDTH = $clog2(MAX_EDGES);
    localparam int unsigned CNT_WIDTH  = $clog2(MAX_EDGES + 2);
    localparam int unsigned DEPTH      = 2 ** DEVICE_WIDTH;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_EDGES);

    localparam logic [2:0] LOAD      = 3'd0;
    localparam logic [2:0] CLEAR     = 3'd1;
    localparam logic [2:0] SEED      = 3'd2;
    localparam logic [2:0] SWEEP     = 3'd3;
    localparam logic [2:0] END_SWEEP = 3'd4;
    localparam logic [2:0] CLEAR_NXT = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    logic [2:0]              state_q, state_d;
    logic [CNT_WIDTH-1:0]    edge_cnt_q, edge_cnt_d, edge_idx_q, edge_idx_d, sweep_q, sweep_d;
    logic [1:0]              phase_q, phase_d;
    logic [DEVICE_WIDTH-1:0] clr_q, clr_d, src_q, src_d, dst_q, dst_d;
    logic                    cur_sel_q, cur_sel_d, any_nz_q, any_nz_d;
    logic                    overflow_q, overflow_d, error_q, error_d;
    logic [RESULT_WIDTH-1:0] total_q, total_d;

    logic [EDGE_WIDTH-1:0]     edge_mem [MAX_EDGES];
    logic [2*DEVICE_WIDTH-1:0] edge_rd_q;
    logic                      edge_we;
    logic [DEVICE_WIDTH-1:0]   rd_dev, rd_next;

    logic [RESULT_WIDTH-1:0] bank_a [DEPTH];
    logic [RESULT_WIDTH-1:0] bank_b [DEPTH];
    logic [RESULT_WIDTH-1:0] a_rdata, b_rdata, a_wdata, b_wdata;
    logic [DEVICE_WIDTH-1:0] a_waddr, b_waddr, a_raddr, b_raddr;
    logic                    a_we, b_we;

    // Logical cur/nxt write ports, mapped onto physical banks by cur_sel_q
    logic                    cur_we, nxt_we;
    logic [DEVICE_WIDTH-1:0] cur_waddr, nxt_waddr;
    logic [RESULT_WIDTH-1:0] cur_wdata, nxt_wdata;
    logic [RESULT_WIDTH-1:0] cur_val, nxt_val, wave_res, total_res;
    logic [RESULT_WIDTH:0]   wave_sum, total_sum;

    // Edge table: captured edge is read every cycle from edge_idx_q.
    always_ff @(posedge clk) begin
        if (edge_we) begin
            edge_mem[edge_cnt_q[EIDX_WIDTH-1:0]] <= {connection_last, device, next_device};
        end
        edge_rd_q <= edge_mem[edge_idx_q[EIDX_WIDTH-1:0]][2*DEVICE_WIDTH-1:0];
    end

    assign rd_dev  = edge_rd_q[2*DEVICE_WIDTH-1:DEVICE_WIDTH];
    assign rd_next = edge_rd_q[DEVICE_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (a_we) begin
            bank_a[a_waddr] <= a_wdata;
        end
        a_rdata <= bank_a[a_raddr];
    end

    always_ff @(posedge clk) begin
        if (b_we) begin
            bank_b[b_waddr] <= b_wdata;
        end
        b_rdata <= bank_b[b_raddr];
    end

    always_comb begin
        a_we    = cur_sel_q ? nxt_we    : cur_we;
        a_waddr = cur_sel_q ? nxt_waddr : cur_waddr;
        a_wdata = cur_sel_q ? nxt_wdata : cur_wdata;
        b_we    = cur_sel_q ? cur_we    : nxt_we;
        b_waddr = cur_sel_q ? cur_waddr : nxt_waddr;
        b_wdata = cur_sel_q ? cur_wdata : nxt_wdata;
        a_raddr = cur_sel_q ? rd_next : rd_dev;
        b_raddr = cur_sel_q ? rd_dev  : rd_next;
    end

    assign cur_val   = cur_sel_q ? b_rdata : a_rdata;
    assign nxt_val   = cur_sel_q ? a_rdata : b_rdata;
    assign wave_sum  = {1'b0, nxt_val} + {1'b0, cur_val};
    assign total_sum = {1'b0, total_q} + {1'b0, cur_val};

    always_comb begin
        wave_res  = wave_sum[RESULT_WIDTH-1:0];
        total_res = total_sum[RESULT_WIDTH-1:0];
`ifdef PATH_COUNT_SATURATE_EN
        if (wave_sum[RESULT_WIDTH]) begin
            wave_res = '1;
        end
        if (total_sum[RESULT_WIDTH]) begin
            total_res = '1;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        edge_idx_d = edge_idx_q;
        sweep_d    = sweep_q;
        phase_d    = phase_q;
        clr_d      = clr_q;
        src_d      = src_q;
        dst_d      = dst_q;
        cur_sel_d  = cur_sel_q;
        any_nz_d   = any_nz_q;
        overflow_d = overflow_q;
        error_d    = error_q;
        total_d    = total_q;
        edge_we    = 1'b0;
        cur_we     = 1'b0;
        cur_waddr  = '0;
        cur_wdata  = '0;
        nxt_we     = 1'b0;
        nxt_waddr  = '0;
        nxt_wdata  = '0;

        case (state_q)
            LOAD: begin
                if (connection_valid) begin
                    if (edge_cnt_q == MAX_CNT) begin
                        error_d = 1'b1;
                    end else begin
                        edge_we    = 1'b1;
                        edge_cnt_d = edge_cnt_q + CNT_ONE;
                    end
                end
                if (end_of_file) begin
                    src_d     = src_device;
                    dst_d     = dst_device;
                    cur_sel_d = 1'b0;
                    clr_d     = '0;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                cur_we    = 1'b1;
                cur_waddr = clr_q;
                nxt_we    = 1'b1;
                nxt_waddr = clr_q;
                clr_d     = clr_q + DEVICE_WIDTH'(1);
                if (clr_q == '1) begin
                    state_d = SEED;
                end
            end
            SEED: begin
                cur_we     = 1'b1;
                cur_waddr  = src_q;
                cur_wdata  = RESULT_WIDTH'(1);
                total_d    = RESULT_WIDTH'(src_q == dst_q);
                sweep_d    = '0;
                edge_idx_d = '0;
                phase_d    = 2'd0;
                any_nz_d   = 1'b0;
                state_d    = (edge_cnt_q == '0) ? DONE : SWEEP;
            end
            SWEEP: begin
                // Slot: c0 edge read, c1 wave reads, c2 accumulate into nxt
                if (phase_q != 2'd2) begin
                    phase_d = phase_q + 2'd1;
                end else begin
                    nxt_we    = 1'b1;
                    nxt_waddr = rd_next;
                    nxt_wdata = wave_res;
                    if (wave_sum[RESULT_WIDTH]) begin
                        overflow_d = 1'b1;
                    end
                    if (cur_val != '0) begin
                        any_nz_d = 1'b1;
                    end
                    if (rd_next == dst_q) begin
                        total_d = total_res;
                        if (total_sum[RESULT_WIDTH]) begin
                            overflow_d = 1'b1;
                        end
                    end
                    phase_d = 2'd0;
                    if (edge_idx_q == edge_cnt_q - CNT_ONE) begin
                        state_d = END_SWEEP;
                    end else begin
                        edge_idx_d = edge_idx_q + CNT_ONE;
                    end
                end
            end
            END_SWEEP: begin
                if (!any_nz_q) begin
                    state_d = DONE;
                end else if (sweep_q >= MAX_CNT) begin
                    // Walks still alive after MAX_EDGES sweeps imply a reachable cycle
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    sweep_d   = sweep_q + CNT_ONE;
                    cur_sel_d = ~cur_sel_q;
                    clr_d     = '0;
                    state_d   = CLEAR_NXT;
                end
            end
            CLEAR_NXT: begin
                nxt_we    = 1'b1;
                nxt_waddr = clr_q;
                clr_d     = clr_q + DEVICE_WIDTH'(1);
                if (clr_q == '1) begin
                    edge_idx_d = '0;
                    phase_d    = 2'd0;
                    any_nz_d   = 1'b0;
                    state_d    = SWEEP;
                end
            end
            DONE: begin
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            state_q    <= LOAD;
            edge_cnt_q <= '0;
            edge_idx_q <= '0;
            sweep_q    <= '0;
            phase_q    <= 2'd0;
            clr_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            cur_sel_q  <= 1'b0;
            any_nz_q   <= 1'b0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            edge_idx_q <= edge_idx_d;
            sweep_q    <= sweep_d;
            phase_q    <= phase_d;
            clr_q      <= clr_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            cur_sel_q  <= cur_sel_d;
            any_nz_q   <= any_nz_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
            total_q    <= total_d;
        end
    end

    assign busy         = (state_q != LOAD) && (state_q != DONE);
    assign result_valid = (state_q == DONE);
    assign result_data  = result_valid ? total_q : '0;
    assign overflow     = overflow_q;
    assign error        = error_q;

endmodule

// File: tb/tb_path_count_processor.sv
// Bench for path_count_processor: directed graphs plus random DAGs against a path-count DP model.
module tb_path_count_processor;

    localparam int DW     = 5;
    localparam int ME     = 40;
    localparam int RW     = 16;
    localparam int NDEV   = 32;
    localparam int BUDGET = 10000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          eof = 1'b0;
    logic          cv  = 1'b0;
    logic          cl  = 1'b0;
    logic [DW-1:0] dev = '0;
    logic [DW-1:0] ndev = '0;
    logic [DW-1:0] src = '0;
    logic [DW-1:0] dst = '0;
    logic          busy, rv, ovf, err;
    logic [RW-1:0] rd;

    int errors = 0;
    int checks = 0;
    int g_from[$];
    int g_to[$];

    always #5 clk = ~clk;

    path_count_processor #(
        .DEVICE_WIDTH(DW),
        .MAX_EDGES   (ME),
        .RESULT_WIDTH(RW)
    ) dut (
        .clk             (clk),
        .test_logic_reset(rst),
        .end_of_file     (eof),
        .connection_valid(cv),
        .connection_last (cl),
        .device          (dev),
        .next_device     (ndev),
        .src_device      (src),
        .dst_device      (dst),
        .busy            (busy),
        .result_valid    (rv),
        .result_data     (rd),
        .overflow        (ovf),
        .error           (err)
    );

    task automatic do_reset();
        rst = 1'b1; eof = 1'b0; cv = 1'b0; cl = 1'b0;
        dev = '0; ndev = '0; src = '0; dst = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_graph();
        g_from.delete();
        g_to.delete();
    endtask

    task automatic add_edge(input int a, input int b);
        g_from.push_back(a);
        g_to.push_back(b);
    endtask

    task automatic add_diamond();
        clear_graph();
        add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3);
    endtask

    // Streams the stored graph, then pulses end_of_file (optionally alongside the last edge).
    task automatic feed_and_start(input int s, input int d, input bit eof_with_last);
        int n;
        n = g_from.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cv = 1'b1; dev = DW'(g_from[i]); ndev = DW'(g_to[i]); cl = (i == n - 1);
            if (eof_with_last && i == n - 1) begin
                eof = 1'b1; src = DW'(s); dst = DW'(d);
            end
        end
        @(negedge clk);
        cv = 1'b0; cl = 1'b0;
        if (!(eof_with_last && n > 0)) begin
            eof = 1'b1; src = DW'(s); dst = DW'(d);
            @(negedge clk);
        end
        eof = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit timed_out);
        cycles = 0;
        while (rv !== 1'b1 && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
        end
        timed_out = (rv !== 1'b1);
    endtask

    // Path count by DP over node IDs; valid for graphs whose edges all go from lower to higher ID.
    task automatic model(input int s, input int d, output longint unsigned cnt, output bit big);
        longint unsigned ways [NDEV];
        for (int v = 0; v < NDEV; v++) ways[v] = 0;
        ways[s] = 1;
        big = 1'b0;
        for (int v = 0; v < NDEV; v++) begin
            for (int e = 0; e < g_from.size(); e++) begin
                if (g_to[e] == v && g_from[e] < v) ways[v] += ways[g_from[e]];
            end
            if (ways[v] >= 64'd65536) big = 1'b1;
        end
        cnt = ways[d];
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (busy !== 1'b0 || rv !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%b result_valid=%b, required 0 0", busy, rv);
        end
        checks++;
        if (rd !== '0 || ovf !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: data=%0d ovf=%b err=%b, required 0 0 0", rd, ovf, err);
        end
    endtask

    task automatic test_diamond();
        int cyc; bit to;
        do_reset();
        add_diamond();
        feed_and_start(0, 3, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL diamond_busy: busy=%b, required 1", busy);
        end
        wait_done(cyc, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL diamond_timeout: result_valid=%b after %0d cycles", rv, cyc);
        end
        checks++;
        if (rd !== 16'd2) begin
            errors++; $display("FAIL diamond_count: got %0d, required 2", rd);
        end
        checks++;
        if (ovf !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL diamond_flags: ovf=%b err=%b busy=%b, required 0 0 0", ovf, err, busy);
        end
    endtask

    task automatic test_puzzle();
        int pf[17] = '{0, 0, 2, 2, 3, 3, 4, 4, 4, 6, 7, 8, 9, 1, 1, 1, 5};
        int pt[17] = '{2, 1, 3, 4, 6, 7, 6, 7, 8, 9, 10, 10, 10, 4, 8, 5, 10};
        int cyc; bit to; bit big; longint unsigned cnt;
        for (int run = 0; run < 2; run++) begin
            do_reset();
            clear_graph();
            for (int i = 0; i < 17; i++) add_edge(pf[i], pt[i]);
            // you=2 first, then aaa=0; end_of_file shares the cycle with the final edge
            feed_and_start(run == 0 ? 2 : 0, 10, 1'b1);
            wait_done(cyc, to);
            model(run == 0 ? 2 : 0, 10, cnt, big);
            checks++;
            if (to || err !== 1'b0 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL puzzle_flags run%0d: to=%b err=%b ovf=%b, required 0 0 0",
                         run, to, err, ovf);
            end
            checks++;
            if (rd !== (run == 0 ? 16'd5 : cnt[15:0])) begin
                errors++;
                $display("FAIL puzzle_count run%0d: got %0d, required %0d", run, rd,
                         run == 0 ? 5 : cnt);
            end
        end
    endtask

    task automatic test_src_eq_dst();
        int cyc; bit to;
        do_reset();
        add_diamond();
        feed_and_start(0, 0, 1'b0);
        wait_done(cyc, to);
        checks++;
        if (to || rd !== 16'd1) begin
            errors++; $display("FAIL src_eq_dst: timeout=%b got %0d, required 1", to, rd);
        end
    endtask

    task automatic test_no_edges();
        int cyc; bit to;
        do_reset();
        clear_graph();
        feed_and_start(3, 4, 1'b0);
        wait_done(cyc, to);
        checks++;
        if (to || cyc > NDEV + 3) begin
            errors++; $display("FAIL no_edges_latency: %0d cycles, required <= %0d", cyc, NDEV + 3);
        end
        checks++;
        if (rd !== 16'd0 || err !== 1'b0) begin
            errors++; $display("FAIL no_edges_count: got %0d err=%b, required 0 0", rd, err);
        end
        do_reset();
        feed_and_start(6, 6, 1'b0);
        wait_done(cyc, to);
        checks++;
        if (to || rd !== 16'd1) begin
            errors++; $display("FAIL no_edges_self: timeout=%b got %0d, required 1", to, rd);
        end
    endtask

    task automatic test_fanout_overflow();
        int cyc; bit to;
        logic [RW-1:0] exp_rd;
`ifdef PATH_COUNT_SATURATE_EN
        exp_rd = 16'hFFFF;
`else
        exp_rd = 16'h0000;
`endif
        do_reset();
        clear_graph();
        // Two parallel edges per stage, 17 stages: 2**17 paths 0 -> 17
        for (int i = 0; i < 17; i++) begin
            add_edge(i, i + 1);
            add_edge(i, i + 1);
        end
        feed_and_start(0, 17, 1'b0);
        wait_done(cyc, to);
        checks++;
        if (to || ovf !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL fanout_flags: to=%b ovf=%b err=%b, required 0 1 0", to, ovf, err);
        end
        checks++;
        if (rd !== exp_rd) begin
            errors++; $display("FAIL fanout_count: got %0h, required %0h", rd, exp_rd);
        end
    endtask

    task automatic test_edge_table_full();
        int cyc; bit to;
        do_reset();
        clear_graph();
        add_edge(0, 1);
        for (int i = 0; i < ME - 1; i++) add_edge(2, 3);
        add_edge(1, 5);  // beyond capacity: would create the only 0 -> 5 path
        feed_and_start(0, 5, 1'b0);
        wait_done(cyc, to);
        checks++;
        if (to || err !== 1'b1) begin
            errors++; $display("FAIL table_full_error: to=%b err=%b, required 0 1", to, err);
        end
        checks++;
        if (rd !== 16'd0) begin
            errors++; $display("FAIL table_full_drop: got %0d, required 0", rd);
        end
    endtask

    task automatic test_cycle_limit();
        int cyc; bit to;
        do_reset();
        clear_graph();
        add_edge(4, 5);
        add_edge(5, 4);
        feed_and_start(4, 9, 1'b0);
        wait_done(cyc, to);
        checks++;
        if (to || rv !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL cycle_limit: to=%b valid=%b err=%b, required 0 1 1", to, rv, err);
        end
        checks++;
        if (rd !== 16'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL cycle_result: got %0d busy=%b, required 0 0", rd, busy);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cyc; bit to;
        do_reset();
        add_diamond();
        feed_and_start(0, 3, 1'b0);
        repeat (NDEV + 4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: busy=%b, required 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rv !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: busy=%b valid=%b err=%b, required 0 0 0", busy, rv, err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        feed_and_start(0, 3, 1'b0);
        wait_done(cyc, to);
        checks++;
        if (to || rd !== 16'd2) begin
            errors++; $display("FAIL midreset_rerun: timeout=%b got %0d, required 2", to, rd);
        end
    endtask

    task automatic test_random();
        int cyc; bit to; bit big; longint unsigned cnt;
        int n, a, b, s, d;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            clear_graph();
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                a = $urandom_range(0, 30);
                b = $urandom_range(a + 1, 31);
                add_edge(a, b);
            end
            s = $urandom_range(0, 12);
            d = $urandom_range(s, 31);
            model(s, d, cnt, big);
            feed_and_start(s, d, 1'($urandom_range(0, 1)));
            wait_done(cyc, to);
            checks++;
            if (to || err !== 1'b0) begin
                errors++; $display("FAIL random%0d_flags: to=%b err=%b, required 0 0", it, to, err);
            end
            if (!big) begin
                checks++;
                if (rd !== cnt[15:0] || ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL random%0d_count: got %0d ovf=%b, required %0d 0",
                             it, rd, ovf, cnt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_diamond();
        test_puzzle();
        test_src_eq_dst();
        test_no_edges();
        test_fanout_overflow();
        test_edge_table_full();
        test_cycle_limit();
        test_reset_mid_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
